// File: rtl/shift_arbiter.sv
// Round-robin front end for a shared bshift_32: accepts one operation at a time,
// holds registered shifter inputs for SETTLE cycles, then returns y/ov/z to the owner.
module shift_arbiter #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [4:0]  req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [4:0]  req1_b,
  input  logic [2:0]  req1_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_y,
  output logic        rsp_ov,
  output logic        rsp_z,
  output logic [31:0] sh_a,
  output logic [4:0]  sh_b,
  output logic        sh_rot,
  output logic        sh_left,
  output logic        sh_arith,
  input  logic [31:0] sh_y,
  input  logic        sh_ov,
  input  logic        sh_z,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t     state, state_nx;
  logic [3:0] cnt;
  logic       last, owner, grant, accept, own_ready;

  // On a tie the requester that did not go last wins; otherwise whoever is asking.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) grant = ~last;
  end

  assign req0_ready = (state == IDLE) && !grant && req0_valid;
  assign req1_ready = (state == IDLE) &&  grant && req1_valid;
  assign accept     = req0_ready || req1_ready;
  assign own_ready  = owner ? rsp1_ready : rsp0_ready;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = EXEC;
      EXEC:    if (cnt == 4'd1) state_nx = RESP;
      RESP:    if (own_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last       <= 1'b1;
      owner      <= 1'b0;
      sh_a       <= '0;
      sh_b       <= '0;
      sh_rot     <= 1'b0;
      sh_left    <= 1'b0;
      sh_arith   <= 1'b0;
      rsp_y      <= '0;
      rsp_ov     <= 1'b0;
      rsp_z      <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (accept) begin
          sh_a                      <= grant ? req1_a  : req0_a;
          sh_b                      <= grant ? req1_b  : req0_b;
          {sh_rot,sh_left,sh_arith} <= grant ? req1_op : req0_op;
          owner                     <= grant;
          last                      <= grant;
          cnt                       <= SETTLE_C;
        end
        EXEC: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            rsp_y  <= sh_y;
            rsp_ov <= sh_ov;
            rsp_z  <= sh_z;
            if (owner) rsp1_valid <= 1'b1;
            else       rsp0_valid <= 1'b1;
          end
        end
        RESP: if (own_ready) begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench: two arbiters (SETTLE=1 and SETTLE=4), each feeding a behavioural bshift_32.
module tb_shift_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural shifter: returns {ov, z, y}; ov flags nonzero bits lost by a logical left shift.
  function automatic logic [33:0] shf(input logic [31:0] a, input logic [4:0] b, input logic [2:0] op);
    logic [31:0] y;
    logic        ov;
    int          sb;
    sb = int'(b);
    ov = 1'b0;
    if (op[2]) y = op[1] ? ((a << sb) | (a >> (32 - sb))) : ((a >> sb) | (a << (32 - sb)));
    else if (op[1]) begin
      y  = a << sb;
      ov = (sb != 0) && ((a >> (32 - sb)) != 32'h0);
    end
    else if (op[0]) y = 32'($signed(a) >>> sb);
    else y = a >> sb;
    return {ov, (y == 32'h0), y};
  endfunction

  // ---- DUT with SETTLE=1 ----
  logic        a_rst = 1'b1;
  logic        a_r0v = 0, a_r1v = 0, a_r0r, a_r1r;
  logic [31:0] a_r0a = 0, a_r1a = 0;
  logic [4:0]  a_r0b = 0, a_r1b = 0;
  logic [2:0]  a_r0op = 0, a_r1op = 0;
  logic        a_p0v, a_p1v, a_p0r = 0, a_p1r = 0;
  logic [31:0] a_y, a_sha, a_shy;
  logic        a_ov, a_z, a_rot, a_left, a_arith, a_shov, a_shz, a_busy;
  logic [4:0]  a_shb;

  assign {a_shov, a_shz, a_shy} = shf(a_sha, a_shb, {a_rot, a_left, a_arith});

  shift_arbiter #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(a_rst),
    .req0_valid(a_r0v), .req0_ready(a_r0r), .req0_a(a_r0a), .req0_b(a_r0b), .req0_op(a_r0op),
    .req1_valid(a_r1v), .req1_ready(a_r1r), .req1_a(a_r1a), .req1_b(a_r1b), .req1_op(a_r1op),
    .rsp0_valid(a_p0v), .rsp0_ready(a_p0r), .rsp1_valid(a_p1v), .rsp1_ready(a_p1r),
    .rsp_y(a_y), .rsp_ov(a_ov), .rsp_z(a_z),
    .sh_a(a_sha), .sh_b(a_shb), .sh_rot(a_rot), .sh_left(a_left), .sh_arith(a_arith),
    .sh_y(a_shy), .sh_ov(a_shov), .sh_z(a_shz), .busy(a_busy)
  );

  // ---- DUT with SETTLE=4 ----
  logic        b_rst = 1'b1;
  logic        b_r0v = 0, b_r1v = 0, b_r0r, b_r1r;
  logic [31:0] b_r0a = 0, b_r1a = 0;
  logic [4:0]  b_r0b = 0, b_r1b = 0;
  logic [2:0]  b_r0op = 0, b_r1op = 0;
  logic        b_p0v, b_p1v, b_p0r = 0, b_p1r = 0;
  logic [31:0] b_y, b_sha, b_shy;
  logic        b_ov, b_z, b_rot, b_left, b_arith, b_shov, b_shz, b_busy;
  logic [4:0]  b_shb;

  assign {b_shov, b_shz, b_shy} = shf(b_sha, b_shb, {b_rot, b_left, b_arith});

  shift_arbiter #(.SETTLE(4)) dut4 (
    .clk(clk), .rst(b_rst),
    .req0_valid(b_r0v), .req0_ready(b_r0r), .req0_a(b_r0a), .req0_b(b_r0b), .req0_op(b_r0op),
    .req1_valid(b_r1v), .req1_ready(b_r1r), .req1_a(b_r1a), .req1_b(b_r1b), .req1_op(b_r1op),
    .rsp0_valid(b_p0v), .rsp0_ready(b_p0r), .rsp1_valid(b_p1v), .rsp1_ready(b_p1r),
    .rsp_y(b_y), .rsp_ov(b_ov), .rsp_z(b_z),
    .sh_a(b_sha), .sh_b(b_shb), .sh_rot(b_rot), .sh_left(b_left), .sh_arith(b_arith),
    .sh_y(b_shy), .sh_ov(b_shov), .sh_z(b_shz), .busy(b_busy)
  );

  // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(); tick(); tick(); #1;
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", a_busy); end
    n_checks++; if ({a_p0v, a_p1v} !== 2'b00) begin n_fail++; $display("FAIL rst_rspv got %b want 00", {a_p0v, a_p1v}); end
    n_checks++; if (a_sha !== 32'h0 || a_shb !== 5'h0 || {a_rot, a_left, a_arith} !== 3'b000) begin
      n_fail++; $display("FAIL rst_sh got %h/%h/%b want 0", a_sha, a_shb, {a_rot, a_left, a_arith}); end
    n_checks++; if ({a_y, a_ov, a_z} !== 34'h0) begin n_fail++; $display("FAIL rst_rsp got %h %b %b want 0", a_y, a_ov, a_z); end
    n_checks++; if (b_busy !== 1'b0 || b_sha !== 32'h0) begin n_fail++; $display("FAIL rst_dut4 got busy=%b sh_a=%h want 0", b_busy, b_sha); end
  endtask

  task automatic test_rotate();
    tick();
    a_rst = 0; a_r0v = 1; a_r0a = 32'h8000_0001; a_r0b = 5'd1; a_r0op = 3'b110; a_p0r = 1;
    #1;
    n_checks++; if ({a_r0r, a_r1r} !== 2'b10) begin n_fail++; $display("FAIL rot_ready got %b want 10", {a_r0r, a_r1r}); end
    tick(); a_r0v = 0; #1;
    n_checks++; if (a_busy !== 1'b1 || a_p0v !== 1'b0) begin n_fail++; $display("FAIL rot_exec got busy=%b v=%b want 1 0", a_busy, a_p0v); end
    n_checks++; if (a_sha !== 32'h8000_0001 || {a_rot, a_left, a_arith} !== 3'b110) begin
      n_fail++; $display("FAIL rot_sh got %h %b want 80000001 110", a_sha, {a_rot, a_left, a_arith}); end
    tick(); #1;
    n_checks++; if ({a_p0v, a_p1v} !== 2'b10) begin n_fail++; $display("FAIL rot_rspv got %b want 10", {a_p0v, a_p1v}); end
    n_checks++; if (a_y !== 32'h0000_0003 || a_z !== 1'b0) begin n_fail++; $display("FAIL rot_y got %h z=%b want 00000003 z=0", a_y, a_z); end
    tick(); #1;
    n_checks++; if ({a_p0v, a_p1v, a_busy} !== 3'b000) begin n_fail++; $display("FAIL rot_done got %b want 000", {a_p0v, a_p1v, a_busy}); end
  endtask

  task automatic test_arith();
    tick();
    a_r1v = 1; a_r1a = 32'h8000_0000; a_r1b = 5'd4; a_r1op = 3'b001; a_p1r = 1;
    #1;
    n_checks++; if ({a_r0r, a_r1r} !== 2'b01) begin n_fail++; $display("FAIL ari_ready got %b want 01", {a_r0r, a_r1r}); end
    tick(); a_r1v = 0; #1;
    n_checks++; if ({a_rot, a_left, a_arith} !== 3'b001 || a_shb !== 5'd4) begin
      n_fail++; $display("FAIL ari_sh got %b b=%0d want 001 b=4", {a_rot, a_left, a_arith}, a_shb); end
    tick(); #1;
    n_checks++; if ({a_p0v, a_p1v} !== 2'b01) begin n_fail++; $display("FAIL ari_rspv got %b want 01", {a_p0v, a_p1v}); end
    n_checks++; if (a_y !== 32'hF800_0000) begin n_fail++; $display("FAIL ari_y got %h want f8000000", a_y); end
    tick(); #1;
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL ari_done got busy=%b want 0", a_busy); end
  endtask

  task automatic test_tie();
    tick(); a_rst = 1;
    tick();
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) begin
        a_rst = 0; a_p0r = 1; a_p1r = 1;
        a_r0v = 1; a_r0a = 32'h1;  a_r0b = 5'd1; a_r0op = 3'b010;
        a_r1v = 1; a_r1a = 32'h10; a_r1b = 5'd4; a_r1op = 3'b000;
      end
      #1;
      n_checks++; if ({a_r0r, a_r1r} !== {(i % 6 == 0), (i % 6 == 3)}) begin
        n_fail++; $display("FAIL tie_grant cyc%0d got %b want %b", i, {a_r0r, a_r1r}, {(i % 6 == 0), (i % 6 == 3)}); end
      n_checks++; if ({a_p0v, a_p1v} !== {(i % 6 == 2), (i % 6 == 5)}) begin
        n_fail++; $display("FAIL tie_rspv cyc%0d got %b want %b", i, {a_p0v, a_p1v}, {(i % 6 == 2), (i % 6 == 5)}); end
      if (i % 3 == 2) begin
        n_checks++; if (a_y !== ((i % 6 == 2) ? 32'h2 : 32'h1)) begin
          n_fail++; $display("FAIL tie_y cyc%0d got %h want %h", i, a_y, (i % 6 == 2) ? 32'h2 : 32'h1); end
      end
    end
    tick(); a_r0v = 0; a_r1v = 0;
    tick();
  endtask

  task automatic test_backpressure();
    tick(); a_rst = 1;
    tick();
    a_rst = 0; a_p0r = 0; a_p1r = 1;
    a_r0v = 1; a_r0a = 32'h1;  a_r0b = 5'd1; a_r0op = 3'b010;
    a_r1v = 1; a_r1a = 32'h10; a_r1b = 5'd4; a_r1op = 3'b000;
    #1;
    n_checks++; if ({a_r0r, a_r1r} !== 2'b10) begin n_fail++; $display("FAIL bp_grant0 got %b want 10", {a_r0r, a_r1r}); end
    tick(); #1;
    n_checks++; if (a_r1r !== 1'b0 || a_busy !== 1'b1) begin n_fail++; $display("FAIL bp_exec got r1=%b busy=%b want 0 1", a_r1r, a_busy); end
    for (int j = 0; j < 5; j++) begin
      tick(); #1;
      n_checks++; if ({a_p0v, a_p1v, a_busy, a_r1r} !== 4'b1010) begin
        n_fail++; $display("FAIL bp_hold cyc%0d got v0v1 busy r1=%b want 1010", j, {a_p0v, a_p1v, a_busy, a_r1r}); end
      n_checks++; if (a_y !== 32'h2) begin n_fail++; $display("FAIL bp_y cyc%0d got %h want 2", j, a_y); end
    end
    a_p0r = 1;
    tick(); #1;
    n_checks++; if ({a_busy, a_p0v, a_r0r, a_r1r} !== 4'b0001) begin
      n_fail++; $display("FAIL bp_idle got busy v0 r0 r1=%b want 0001", {a_busy, a_p0v, a_r0r, a_r1r}); end
    tick(); a_r0v = 0; a_r1v = 0; #1;
    n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL bp_req1 got busy=%b want 1", a_busy); end
    tick(); #1;
    n_checks++; if ({a_p0v, a_p1v} !== 2'b01 || a_y !== 32'h1) begin
      n_fail++; $display("FAIL bp_rsp1 got %b y=%h want 01 y=1", {a_p0v, a_p1v}, a_y); end
    tick();
  endtask

  task automatic test_settle();
    tick();
    b_rst = 0; b_r0v = 1; b_r0a = 32'h1; b_r0b = 5'd31; b_r0op = 3'b010; b_p0r = 1;
    #1;
    n_checks++; if (b_r0r !== 1'b1) begin n_fail++; $display("FAIL st_ready got %b want 1", b_r0r); end
    tick(); b_r0v = 0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      n_checks++; if (b_sha !== 32'h1 || b_shb !== 5'd31 || b_busy !== 1'b1 || b_p0v !== 1'b0) begin
        n_fail++; $display("FAIL st_exec cyc%0d got a=%h b=%0d busy=%b v=%b want 1 31 1 0", c, b_sha, b_shb, b_busy, b_p0v); end
      tick();
    end
    #1;
    n_checks++; if (b_p0v !== 1'b1 || b_y !== 32'h8000_0000 || b_ov !== 1'b0) begin
      n_fail++; $display("FAIL st_rsp got v=%b y=%h ov=%b want 1 80000000 0", b_p0v, b_y, b_ov); end
    tick(); #1;
    n_checks++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL st_done got busy=%b want 0", b_busy); end
  endtask

  task automatic test_reset_mid();
    tick();
    b_r0v = 1; b_r0a = 32'h1234; b_r0b = 5'd0; b_r0op = 3'b000;
    #1;
    n_checks++; if (b_r0r !== 1'b1) begin n_fail++; $display("FAIL rm_ready got %b want 1", b_r0r); end
    tick(); b_r0v = 0;
    tick(); b_rst = 1;
    tick(); #1;
    n_checks++; if ({b_busy, b_p0v, b_p1v} !== 3'b000 || b_sha !== 32'h0) begin
      n_fail++; $display("FAIL rm_state got busy v0 v1=%b sh_a=%h want 000 0", {b_busy, b_p0v, b_p1v}, b_sha); end
    b_rst = 0; b_r0v = 1; b_r1v = 1; b_r1a = 32'h5; b_p1r = 1;
    #1;
    n_checks++; if ({b_r0r, b_r1r} !== 2'b10) begin n_fail++; $display("FAIL rm_tie got %b want 10", {b_r0r, b_r1r}); end
    tick(); b_r0v = 0; b_r1v = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if ({b_p0v, b_p1v} !== 2'b00) begin n_fail++; $display("FAIL rm_norsp cyc%0d got %b want 00", c, {b_p0v, b_p1v}); end
      tick();
    end
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_arith();
    test_tie();
    test_backpressure();
    test_settle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
Round-robin controller that shares one bshift_32 barrel shifter between two requesters, for example the integer ALU path and the address-generation path. It accepts an operation from one requester at a time over a valid/ready handshake and drives registered operands and controls into the shifter. It holds them for a programmable settle time, captures y/ov/z and returns them to the granted requester over a valid/ready response handshake.

Parameters:
- SETTLE, 1: number of EXEC cycles the shifter inputs are held stable before the outputs are sampled. Legal range is 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  32  requester 0 operand.
- req0_b  in  5  requester 0 shift amount.
- req0_op  in  3  requester 0 op, {rot,left,arith}.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- rsp0_valid  out  1  result valid for requester 0.
- rsp0_ready  in  1  requester 0 accepts the result.
- rsp1_valid  out  1  result valid for requester 1.
- rsp1_ready  in  1  requester 1 accepts the result.
- rsp_y  out  32  captured shifter result (shared by both requesters).
- rsp_ov  out  1  captured overflow flag.
- rsp_z  out  1  captured zero flag.
- sh_a  out  32  to bshift_32 a.
- sh_b  out  5  to bshift_32 b.
- sh_rot  out  1  to bshift_32 rot.
- sh_left  out  1  to bshift_32 left.
- sh_arith  out  1  to bshift_32 arith.
- sh_y  in  32  from bshift_32 y.
- sh_ov  in  1  from bshift_32 ov.
- sh_z  in  1  from bshift_32 z.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- States are IDLE, EXEC and RESP. All state and outputs are registered except reqN_ready, which is decoded combinationally from state and grant.
- Reset (rst=1 at an edge):
  - state=IDLE, cnt=0, last=1 (so requester 0 wins the first tie), owner=0.
  - sh_* = 0, rsp_y = 0, rsp_ov = 0, rsp_z = 0, rsp0_valid = rsp1_valid = 0.
  - Reset mid-EXEC or mid-RESP discards the operation; no response is issued.
- Grant, in IDLE only:
  - Only reqN_valid set: grant N.
  - Both set: grant the requester not equal to last.
  - reqN_ready = (state==IDLE) && grant==N && reqN_valid. At most one ready is high per cycle, and both are 0 outside IDLE.
- Accept edge (valid && ready):
  - sh_a <= reqN_a, sh_b <= reqN_b, {sh_rot,sh_left,sh_arith} <= reqN_op.
  - owner <= N, last <= N, cnt <= SETTLE, state <= EXEC.
- EXEC:
  - sh_* are held constant and cnt decrements each cycle.
  - At the edge where cnt==1: rsp_y <= sh_y, rsp_ov <= sh_ov, rsp_z <= sh_z, rsp[owner]_valid <= 1, state <= RESP.
- RESP:
  - rsp[owner]_valid and rsp_* are held until rsp[owner]_ready=1 at an edge.
  - At that edge: valid <= 0, state <= IDLE.
  - The readiness of the non-owner is ignored. sh_* keep their last values.
- Latency: an accept at edge k gives rsp valid from the cycle after edge k+SETTLE.
  - Minimum issue interval is SETTLE+2 cycles, because IDLE costs one cycle after each response.
- Requesters hold valid and payload until ready. A request withdrawn before grant is simply not serviced.
- reqN_op is passed through unchecked. Encoding matches the bshift_32 controls; for example 3'b110 is rotate-left and 3'b001 is arithmetic shift right.
- Both requests valid continuously gives a strictly alternating grant sequence 0,1,0,1...

Test Plan:
- Rotate left, SETTLE=1: after reset, req0 a=0x80000001, b=1, op=110, rsp0_ready=1.
  - req0_ready is high in cycle 1.
  - rsp0_valid is high exactly one cycle, 2 cycles after the accept, with rsp_y=0x00000003.
  - rsp1_valid stays 0.
- Arithmetic shift right: req1 a=0x80000000, b=4, op=001.
  - rsp1 carries rsp_y=0xF8000000; sh_arith=1 throughout EXEC.
- Tie breaking: req0 and req1 both valid from reset, rsp ready tied high.
  - Grants go 0,1,0,1, with accepts 3 cycles apart at SETTLE=1.
- Response backpressure: rsp0_ready=0 for 5 cycles.
  - rsp0_valid and rsp_y stay stable and busy=1.
  - req1_ready stays 0 throughout.
  - After ready rises, IDLE lasts 1 cycle and then req1 is granted.
- Settle parameter: SETTLE=4 with a=0x00000001, b=31, op=010 (logical shift left).
  - sh_a stays stable for 4 EXEC cycles; rsp_y=0x80000000 arrives 5 cycles after the accept.
- Reset mid-operation: assert rst in the second EXEC cycle.
  - Next cycle state=IDLE, sh_a=0, no rsp valid.
  - last=1, so a following tie grants req0.
